// File: rtl/pll_lock_sequencer.sv
// PLL supervisor: pulses the PLL reset, waits (with timeout and retries) for LOCK,
// qualifies LOCK for a stable period, then releases the PLL-domain reset.
module pll_lock_sequencer #(
  parameter int RESET_CYCLES        = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               pll_lock,
  input  logic                               soft_req,
  output logic                               pll_reset,
  output logic                               sys_rst_n,
  output logic                               ready,
  output logic                               fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
  output logic [2:0]                         state
);

  localparam int CNT_MAX_A = (RESET_CYCLES > LOCK_STABLE_CYCLES) ? RESET_CYCLES : LOCK_STABLE_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > LOCK_TIMEOUT_CYCLES) ? CNT_MAX_A : LOCK_TIMEOUT_CYCLES;
  localparam int CW        = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int RW        = $clog2(MAX_RETRIES + 1);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [RW-1:0]   retry_reg, retry_next;
  logic            lock_meta_reg, lock_s_reg;
  logic            cnt_hold;

  // pll_lock is asynchronous to clk; only lock_s_reg is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_reg <= 1'b0;
      lock_s_reg    <= 1'b0;
    end else begin
      lock_meta_reg <= pll_lock;
      lock_s_reg    <= lock_meta_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_PLL_RST;
      cnt_reg   <= '0;
      retry_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      retry_reg <= retry_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    retry_next = retry_reg;
    cnt_hold   = 1'b0;
    if (soft_req) begin
      state_next = S_PLL_RST;
      retry_next = '0;
    end else begin
      case (state_reg)
        S_PLL_RST: begin
          if (cnt_reg == CW'(RESET_CYCLES - 1)) state_next = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          // A lock arriving on the timeout cycle wins over the timeout.
          if (lock_s_reg) begin
            state_next = S_STABLE;
          end else if (cnt_reg == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
            retry_next = retry_reg + RW'(1);
            state_next = (retry_next == RW'(MAX_RETRIES)) ? S_FAIL : S_PLL_RST;
          end
        end
        S_STABLE: begin
          // A drop on the completing cycle still counts as a drop.
          if (!lock_s_reg) begin
            state_next = S_WAIT_LOCK;
          end else if (cnt_reg == CW'(LOCK_STABLE_CYCLES - 1)) begin
            state_next = S_RUN;
            retry_next = '0;
          end
        end
        S_RUN: begin
          cnt_hold = 1'b1;
          if (!lock_s_reg) state_next = S_PLL_RST;
        end
        S_FAIL: begin
          cnt_hold = 1'b1;
        end
        default: begin
          state_next = S_PLL_RST;
        end
      endcase
    end
    if (soft_req || (state_next != state_reg)) cnt_next = '0;
    else if (cnt_hold)                          cnt_next = cnt_reg;
    else                                        cnt_next = cnt_reg + CW'(1);
  end

  assign pll_reset = (state_reg == S_PLL_RST);
  assign sys_rst_n = (state_reg == S_RUN);
  assign ready     = (state_reg == S_RUN);
  assign fail      = (state_reg == S_FAIL);
  assign retry_cnt = retry_reg;
  assign state     = state_reg;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small parameters (4/8/32/2);
// every expected value below is hand-derived from the sequencing rules.
module tb_pll_lock_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_lock;
  logic       soft_req;
  logic       pll_reset;
  logic       sys_rst_n;
  logic       ready;
  logic       fail;
  logic [1:0] retry_cnt;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;

  pll_lock_sequencer #(
    .RESET_CYCLES(4),
    .LOCK_STABLE_CYCLES(8),
    .LOCK_TIMEOUT_CYCLES(32),
    .MAX_RETRIES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pll_lock(pll_lock),
    .soft_req(soft_req),
    .pll_reset(pll_reset),
    .sys_rst_n(sys_rst_n),
    .ready(ready),
    .fail(fail),
    .retry_cnt(retry_cnt),
    .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    $display("chk %s obs=%0d exp=%0d", tag, obs, exp);
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and sample 1 time unit after the last one.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int st, input int pr, input int sr,
                           input int rd, input int fl, input int rc);
    check({tag, ".state"}, int'(state), st);
    check({tag, ".pll_reset"}, int'(pll_reset), pr);
    check({tag, ".sys_rst_n"}, int'(sys_rst_n), sr);
    check({tag, ".ready"}, int'(ready), rd);
    check({tag, ".fail"}, int'(fail), fl);
    check({tag, ".retry_cnt"}, int'(retry_cnt), rc);
  endtask

  initial begin
    rst_n    = 1'b0;
    pll_lock = 1'b0;
    soft_req = 1'b0;
    cyc(3);
    check_all("reset", 0, 1, 0, 0, 0, 0);

    // Normal bring-up: 4-cycle PLL reset, lock raised 10 edges after release.
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cyc(1);
      check("bringup.pll_rst_state", int'(state), 0);
      check("bringup.pll_reset_hi", int'(pll_reset), 1);
    end
    cyc(1);
    check("bringup.wait_state", int'(state), 1);
    check("bringup.pll_reset_lo", int'(pll_reset), 0);
    cyc(6);
    check("bringup.still_wait", int'(state), 1);
    pll_lock = 1'b1;
    cyc(2);
    check("bringup.sync_latency", int'(state), 1);
    cyc(1);
    check("bringup.stable", int'(state), 2);
    cyc(7);
    check("bringup.stable_7", int'(state), 2);
    check("bringup.sysrst_low", int'(sys_rst_n), 0);
    cyc(1);
    check_all("bringup.run", 3, 0, 1, 1, 0, 0);

    // Lock loss in RUN: PLL_RST two edges after the edge that first sees pll_lock low.
    pll_lock = 1'b0;
    cyc(2);
    check("lossrun.still_run", int'(state), 3);
    check("lossrun.sysrst_hi", int'(sys_rst_n), 1);
    pll_lock = 1'b1;
    cyc(1);
    check_all("lossrun.pll_rst", 0, 1, 0, 0, 0, 0);
    cyc(3);
    check("lossrun.pulse_end", int'(pll_reset), 1);
    cyc(1);
    check("lossrun.wait", int'(state), 1);
    cyc(1);
    check("lossrun.stable", int'(state), 2);

    // Glitchy lock at stable-count 5; the drop lands on the completing cycle.
    cyc(5);
    pll_lock = 1'b0;
    cyc(2);
    check("glitch.stable_cnt7", int'(state), 2);
    cyc(1);
    check("glitch.drop_wins", int'(state), 1);
    pll_lock = 1'b1;
    cyc(2);
    check("glitch.wait", int'(state), 1);
    cyc(1);
    check("glitch.restable", int'(state), 2);
    cyc(7);
    check("glitch.full_count", int'(state), 2);
    cyc(1);
    check_all("glitch.run", 3, 0, 1, 1, 0, 0);

    // soft_req in RUN, then hold lock low for two timeouts into FAIL.
    soft_req = 1'b1;
    pll_lock = 1'b0;
    cyc(1);
    soft_req = 1'b0;
    check_all("softrun", 0, 1, 0, 0, 0, 0);
    cyc(4);
    check("timeout.wait1", int'(state), 1);
    cyc(31);
    check("timeout.wait1_end", int'(state), 1);
    check("timeout.retry0", int'(retry_cnt), 0);
    cyc(1);
    check("timeout.back_rst", int'(state), 0);
    check("timeout.retry1", int'(retry_cnt), 1);
    cyc(4);
    check("timeout.wait2", int'(state), 1);
    cyc(31);
    check("timeout.wait2_end", int'(state), 1);
    cyc(1);
    check_all("timeout.fail", 4, 0, 0, 0, 1, 2);
    cyc(10);
    check_all("timeout.fail_hold", 4, 0, 0, 0, 1, 2);

    // soft_req in FAIL, then bring up again with lock already present.
    soft_req = 1'b1;
    pll_lock = 1'b1;
    cyc(1);
    soft_req = 1'b0;
    check_all("softfail", 0, 1, 0, 0, 0, 0);
    cyc(4);
    check("softfail.wait", int'(state), 1);
    cyc(1);
    check("softfail.stable", int'(state), 2);
    cyc(4);
    check("async.mid_stable", int'(state), 2);

    // Asynchronous reset mid-count: outputs change without a clock edge.
    rst_n = 1'b0;
    #1;
    check_all("async.immediate", 0, 1, 0, 0, 0, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    check("async.pulse_3", int'(pll_reset), 1);
    cyc(1);
    check("async.wait", int'(state), 1);
    check("async.pll_reset_lo", int'(pll_reset), 0);
    cyc(1);
    check("async.stable", int'(state), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
